// File: rtl/video_uart_pkg.sv
// Shared types for the video-to-UART bridge.
//   state_e      : serializer FSM states
//   fifo_entry_t : one buffered video word plus its start-of-frame flag
package video_uart_pkg;

  typedef enum logic [1:0] {StIdle, StHdrSync, StHdrSeq, StData} state_e;

  localparam logic [7:0] DefaultSyncByte = 8'hA5;

  // Widest legal video word; entries are zero-extended to this width.
  localparam int unsigned MaxDataWidth = 512;

  typedef struct packed {
    logic                    sof;
    logic [MaxDataWidth-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy, full and empty flags.
// Read data is first-word fall-through (valid whenever empty is low).
//   clk, rst        : clock, synchronous active-high reset
//   wr_en, wr_data  : push (ignored when full, even if a pop happens this cycle)
//   rd_en, rd_data  : pop (ignored when empty), head entry
//   count, full, empty : registered status
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CntOne = (AW+1)'(1);
  localparam logic [AW:0] CntMax = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             do_wr, do_rd;

  assign do_wr = wr_en && !full_q;
  assign do_rd = rd_en && !empty_q;

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + CntOne;
    end else if (do_rd && !do_wr) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CntMax);
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/video_uart_bridge.sv
// Decimates an AXI-Stream video word stream, buffers kept words and serializes
// them little-endian onto an 8-bit stream for a UART transmitter. Words flagged
// start-of-frame are preceded by SYNC_BYTE and an 8-bit frame sequence number.
//   clk, rst      : clock, synchronous active-high reset
//   s_axis_*      : video input (never back-pressured)
//   m_axis_*      : byte output to the UART
//   drop_count    : saturating count of kept words lost to a full FIFO
//   fifo_level    : current FIFO occupancy
module video_uart_bridge
  import video_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DECIM      = 1,
  parameter logic [7:0]  SYNC_BYTE  = DefaultSyncByte
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tuser,
  output logic                          s_axis_tready,
  output logic [7:0]                    m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [15:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned IW       = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam logic [IW-1:0] LastIdx  = IW'(NumBytes - 1);
  localparam logic [15:0]   DecLast  = 16'(DECIM - 1);
  // After a start-of-frame word the next word is the 2nd of the decimation window.
  localparam logic [15:0]   DecAfterSof = (DECIM > 1) ? 16'd1 : 16'd0;

  logic [15:0]             dec_cnt_q;
  logic [15:0]             drop_cnt_q;
  logic                    keep;
  logic                    fifo_full, fifo_empty, fifo_pop;
  logic [DATA_WIDTH:0]     fifo_rd;
  fifo_entry_t             rd_entry;

  state_e                  state_q;
  logic                    tvalid_q;
  logic [7:0]              tdata_q;
  logic [IW-1:0]           byte_idx_q, byte_idx_inc;
  logic [7:0]              seq_q;
  logic [MaxDataWidth-1:0] word_q;

  assign s_axis_tready = 1'b1;

  assign keep = s_axis_tvalid && (s_axis_tuser || (dec_cnt_q == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (s_axis_tvalid) begin
        if (s_axis_tuser)            dec_cnt_q <= DecAfterSof;
        else if (dec_cnt_q == DecLast) dec_cnt_q <= '0;
        else                         dec_cnt_q <= dec_cnt_q + 16'd1;
      end
      if (keep && fifo_full && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign fifo_pop = (state_q == StIdle) && !fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (keep),
    .wr_data ({s_axis_tuser, s_axis_tdata}),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd),
    .count   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    rd_entry                      = '0;
    rd_entry.sof                  = fifo_rd[DATA_WIDTH];
    rd_entry.data[DATA_WIDTH-1:0] = fifo_rd[DATA_WIDTH-1:0];
  end

  assign byte_idx_inc = byte_idx_q + IW'(1);

  // Outputs are registered: tdata_q is loaded with the byte for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      byte_idx_q <= '0;
      seq_q      <= '0;
      word_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            word_q     <= rd_entry.data;
            byte_idx_q <= '0;
            tvalid_q   <= 1'b1;
            if (rd_entry.sof) begin
              state_q <= StHdrSync;
              tdata_q <= SYNC_BYTE;
            end else begin
              state_q <= StData;
              tdata_q <= rd_entry.data[7:0];
            end
          end
        end
        StHdrSync: begin
          if (m_axis_tready) begin
            state_q <= StHdrSeq;
            tdata_q <= seq_q;
          end
        end
        StHdrSeq: begin
          if (m_axis_tready) begin
            seq_q      <= seq_q + 8'd1;
            state_q    <= StData;
            byte_idx_q <= '0;
            tdata_q    <= word_q[7:0];
          end
        end
        StData: begin
          if (m_axis_tready) begin
            if (byte_idx_q == LastIdx) begin
              state_q  <= StIdle;
              tvalid_q <= 1'b0;
              tdata_q  <= '0;
            end else begin
              byte_idx_q <= byte_idx_inc;
              tdata_q    <= 8'(word_q >> {byte_idx_inc, 3'b000});
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_video_uart_bridge.sv
module tb_video_uart_bridge;

  localparam int DW = 32;
  localparam int NB = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Main DUT: DECIM=1, FIFO_DEPTH=4
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tuser, s_tready;
  logic [7:0]    m_tdata;
  logic          m_tvalid, m_tready;
  logic [15:0]   drop_count;
  logic [2:0]    fifo_level;

  // Decimating DUT: DECIM=4, FIFO_DEPTH=16
  logic [DW-1:0] d_s_tdata;
  logic          d_s_tvalid, d_s_tuser, d_s_tready;
  logic [7:0]    d_m_tdata;
  logic          d_m_tvalid, d_m_tready;
  logic [15:0]   d_drop_count;
  logic [4:0]    d_fifo_level;

  video_uart_bridge #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (4),
    .DECIM      (1),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tuser  (s_tuser),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .drop_count    (drop_count),
    .fifo_level    (fifo_level)
  );

  video_uart_bridge #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (16),
    .DECIM      (4),
    .SYNC_BYTE  (8'hA5)
  ) dut_d (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (d_s_tdata),
    .s_axis_tvalid (d_s_tvalid),
    .s_axis_tuser  (d_s_tuser),
    .s_axis_tready (d_s_tready),
    .m_axis_tdata  (d_m_tdata),
    .m_axis_tvalid (d_m_tvalid),
    .m_axis_tready (d_m_tready),
    .drop_count    (d_drop_count),
    .fifo_level    (d_fifo_level)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_d_q[$];
  logic [7:0] seq_model = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor for the main DUT; also checks tdata hold during stalls.
  initial begin
    logic       stall_prev;
    logic [7:0] data_prev;
    logic [7:0] e;
    stall_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_tvalid", {31'b0, m_tvalid}, 32'd1);
          chk("hold_tdata", {24'b0, m_tdata}, {24'b0, data_prev});
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", {24'b0, m_tdata}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("byte", {24'b0, m_tdata}, {24'b0, e});
          end
        end
        stall_prev = m_tvalid && !m_tready;
        data_prev  = m_tdata;
      end
    end
  end

  // Scoreboard monitor for the decimating DUT.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && d_m_tvalid && d_m_tready) begin
        if (exp_d_q.size() == 0) begin
          chk("d_unexpected_byte", {24'b0, d_m_tdata}, 32'hFFFF_FFFF);
        end else begin
          e = exp_d_q.pop_front();
          chk("d_byte", {24'b0, d_m_tdata}, {24'b0, e});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic push_word(input logic [DW-1:0] d, input logic u);
    if (u) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(seq_model);
      seq_model = seq_model + 8'd1;
    end
    for (int b = 0; b < NB; b++) exp_q.push_back(d[8*b +: 8]);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic u);
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tuser  = u;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid || fifo_level != 0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {31'b0, (n < 2000)}, 32'd1);
  endtask

  initial begin
    logic [DW-1:0] w;
    int n;

    rst        = 1'b1;
    s_tdata    = 32'hDEAD_BEEF;
    s_tvalid   = 1'b1;
    s_tuser    = 1'b1;
    m_tready   = 1'b0;
    d_s_tdata  = '0;
    d_s_tvalid = 1'b0;
    d_s_tuser  = 1'b0;
    d_m_tready = 1'b1;

    // Reset with traffic on the input, which must be ignored.
    repeat (3) @(posedge clk);
    #1;
    chk("tready_in_reset", {31'b0, s_tready}, 32'd1);
    rst      = 1'b0;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    chk("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
    chk("rst_tdata", {24'b0, m_tdata}, 32'd0);
    chk("rst_drop", {16'b0, drop_count}, 32'd0);
    chk("rst_level", {29'b0, fifo_level}, 32'd0);
    @(posedge clk); #1;
    chk("rst_idle_tvalid", {31'b0, m_tvalid}, 32'd0);

    // Single start-of-frame word: A5,00,11,22,33,44 with two-edge latency.
    m_tready = 1'b1;
    push_word(32'h4433_2211, 1'b1);
    s_tdata  = 32'h4433_2211;
    s_tvalid = 1'b1;
    s_tuser  = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    chk("lat_edge_k", {31'b0, m_tvalid}, 32'd0);
    chk("lat_level", {29'b0, fifo_level}, 32'd1);
    @(posedge clk); #1;
    chk("lat_edge_k1", {31'b0, m_tvalid}, 32'd1);
    chk("lat_first_byte", {24'b0, m_tdata}, 32'hA5);
    wait_idle("drain_single");

    // Two back-to-back words: second write coincides with first pop.
    push_word(32'h0807_0605, 1'b0);
    push_word(32'h0C0B_0A09, 1'b0);
    send(32'h0807_0605, 1'b0);
    chk("b2b_level1", {29'b0, fifo_level}, 32'd1);
    send(32'h0C0B_0A09, 1'b0);
    chk("b2b_level_wr_pop", {29'b0, fifo_level}, 32'd1);
    wait_idle("drain_b2b");

    // Overflow: serializer holds a stalled word, then 6 more words into depth 4.
    m_tready = 1'b0;
    push_word(32'hA1A2_A3A4, 1'b0);
    send(32'hA1A2_A3A4, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ovf_pre_level", {29'b0, fifo_level}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      w = {8'(8'h50 + 4*i + 3), 8'(8'h50 + 4*i + 2), 8'(8'h50 + 4*i + 1), 8'(8'h50 + 4*i)};
      if (i < 4) push_word(w, 1'b0);
      send(w, 1'b0);
    end
    chk("ovf_level", {29'b0, fifo_level}, 32'd4);
    chk("ovf_drop", {16'b0, drop_count}, 32'd2);
    chk("ovf_hold_byte", {24'b0, m_tdata}, 32'hA4);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_hold_byte_later", {24'b0, m_tdata}, 32'hA4);

    // Drain with tready toggling 1010...
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 2000) begin
      m_tready = ~m_tready;
      @(posedge clk); #1;
      n++;
    end
    chk("toggle_drain", {31'b0, (n < 2000)}, 32'd1);
    chk("toggle_drop", {16'b0, drop_count}, 32'd2);
    m_tready = 1'b1;
    wait_idle("toggle_idle");

    // Decimation by 4 on the second DUT: only words 0 and 4 survive.
    exp_d_q.push_back(8'hA5);
    exp_d_q.push_back(8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || i == 4) begin
        exp_d_q.push_back(8'(8'hD0 + i));
        exp_d_q.push_back(8'hC3);
        exp_d_q.push_back(8'hB2);
        exp_d_q.push_back(8'(i));
      end
    end
    for (int i = 0; i < 8; i++) begin
      d_s_tdata  = {8'(i), 8'hB2, 8'hC3, 8'(8'hD0 + i)};
      d_s_tvalid = 1'b1;
      d_s_tuser  = (i == 0);
      @(posedge clk); #1;
    end
    d_s_tvalid = 1'b0;
    d_s_tuser  = 1'b0;
    n = 0;
    while ((exp_d_q.size() != 0 || d_m_tvalid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("decim_drain", {31'b0, (n < 500)}, 32'd1);
    chk("decim_drop", {16'b0, d_drop_count}, 32'd0);

    // Reset after two bytes of a word, with another word still buffered.
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hBB);
    send(32'hDDCC_BBAA, 1'b0);
    send(32'h7777_7777, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_byte", {24'b0, m_tdata}, 32'hCC);
    rst      = 1'b1;
    m_tready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_tvalid", {31'b0, m_tvalid}, 32'd0);
    chk("midrst_level", {29'b0, fifo_level}, 32'd0);
    chk("midrst_drop", {16'b0, drop_count}, 32'd0);
    m_tready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_quiet", {31'b0, m_tvalid}, 32'd0);
    seq_model = 8'h00;
    push_word(32'h0403_0201, 1'b1);
    send(32'h0403_0201, 1'b1);
    wait_idle("post_rst_frame");

    // 256 more frames: sequence 01..FF then wraps to 00.
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'(i ^ 8'h5A), 8'(~i), 8'(i + 3)};
      push_word(w, 1'b1);
      send(w, 1'b1);
      repeat (7) @(posedge clk);
      #1;
    end
    wait_idle("seq_drain");
    chk("seq_wrapped", {24'b0, seq_model}, 32'h01);

    chk("queue_empty", exp_q.size(), 32'd0);
    chk("d_queue_empty", exp_d_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_uart_bridge.md
VIDEO_UART_BRIDGE -- requirements
Module: video_uart_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, input word width in bits; legal range is a multiple of 8 from 8 to 512.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, buffered words; legal values are powers of 2 from 2 to 256.
REQ-003 SHALL have parameter DECIM, default 1, decimation factor; keep 1 word of every DECIM; legal range 1 to 65535.
REQ-004 SHALL have parameter SYNC_BYTE, default 8'hA5, frame header marker byte.
REQ-005 SHALL use one clock, clk; reset is synchronous and active-high, port rst.
REQ-006 SHALL have ports: clk  in  1  sole clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 s_axis_tdata  in  DATA_WIDTH  video word.
REQ-009 s_axis_tvalid  in  1  word valid.
REQ-010 s_axis_tuser  in  1  start-of-frame, qualified by tvalid.
REQ-011 s_axis_tready  out  1  tied high; the video stream is never back-pressured.
REQ-012 m_axis_tdata  out  8  byte to the UART transmitter.
REQ-013 m_axis_tvalid  out  1  byte valid.
REQ-014 m_axis_tready  in  1  UART ready.
REQ-015 drop_count  out  16  saturating count of dropped words.
REQ-016 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 SHALL keep a word when s_axis_tvalid=1 and either tuser=1 or the decimation counter is 0; the counter SHALL step 0..DECIM-1 and wrap, and SHALL restart at 1 after a tuser word.
REQ-018 SHALL write each kept word with its sof flag into the FIFO in the same edge, provided the registered fifo_level < FIFO_DEPTH.
REQ-019 SHALL drop a kept word when the FIFO is full; a pop in the same cycle does not make room; drop_count SHALL increment and saturate at 16'hFFFF.
REQ-020 SHALL implement serializer FSM states IDLE, HDR_SYNC, HDR_SEQ, DATA.
REQ-021 IDLE: when the FIFO is non-empty, SHALL pop one word at the edge; next state is HDR_SYNC if sof=1, else DATA with byte index 0.
REQ-022 HDR_SYNC SHALL present SYNC_BYTE; on handshake, go to HDR_SEQ.
REQ-023 HDR_SEQ SHALL present the 8-bit frame sequence number; on handshake, increment it (wrap 255 to 0) and go to DATA with index 0.
REQ-024 DATA SHALL present word[8*i+7:8*i], little-endian byte order; on handshake, increment i; after byte DATA_WIDTH/8-1, go to IDLE.
REQ-025 m_axis_tvalid SHALL be 1 exactly in HDR_SYNC, HDR_SEQ and DATA; tdata SHALL stay stable while tvalid=1 and tready=0.
REQ-026 A handshake is m_axis_tvalid and m_axis_tready both 1 at a rising edge.
REQ-027 Latency: a word accepted into an empty FIFO with the FSM in IDLE at edge k SHALL give m_axis_tvalid=1 after edge k+1.
REQ-028 Back-to-back: IDLE SHALL last exactly one cycle between words when the FIFO is non-empty.
REQ-029 Simultaneous write and pop SHALL leave fifo_level unchanged.

Reset
REQ-030 On rst=1 at an edge, SHALL set: m_axis_tvalid=0, m_axis_tdata=0, drop_count=0, fifo_level=0, FSM=IDLE, sequence number=0, decimation counter=0, byte index=0.
REQ-031 Reset mid-transfer SHALL discard the partial word and all FIFO contents; no further bytes of that word are emitted.
REQ-032 s_axis_tready SHALL read 1 during reset; inputs are ignored while rst=1.

Structure
REQ-033 Package video_uart_pkg SHALL hold the FSM state typedef, the default SYNC_BYTE constant and the FIFO entry struct {sof, data}.
REQ-034 SHALL instantiate one sub-module, sync_fifo, parametrised by width (DATA_WIDTH+1) and depth, with registered count, full and empty.

Verification
REQ-035 DATA_WIDTH=32, DECIM=1: one tuser word 32'h44332211, tready=1 -> bytes A5,00,11,22,33,44; tvalid first seen 2 cycles after input.
REQ-036 DECIM=4: 8 consecutive words, tuser on word 0 -> only words 0 and 4 serialized; only word 0 gets a header.
REQ-037 FIFO_DEPTH=4, tready=0, 6 words -> fifo_level=4, drop_count=2, first byte held stable.
REQ-038 tready toggling 1010... -> no byte lost or duplicated; tdata constant while tready=0.
REQ-039 256 tuser frames -> sequence bytes 00..FF, then 00 again.
REQ-040 rst pulsed after byte 2 of a word -> tvalid=0 next cycle, fifo_level=0; the next frame starts A5,00.
